// File: rtl/ysyx_24100029_br_pkg.sv
// Shared types for the branch-commit block: branch kinds,
// commit FSM states and the predictor-update record.
package ysyx_24100029_br_pkg;

    localparam logic [1:0] BR_TYPE_PLAIN = 2'b00;
    localparam logic [1:0] BR_TYPE_CALL  = 2'b01;
    localparam logic [1:0] BR_TYPE_RET   = 2'b10;

    typedef enum logic {
        RUN,
        FLUSH
    } br_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  br_type;
        logic [31:0] npc;
        logic        taken;
    } br_entry_t;

endpackage

// File: rtl/ysyx_24100029_br_fifo.sv
// Synchronous update queue between branch resolution and the
// predictor; power-of-two depth so pointers wrap naturally.
module ysyx_24100029_br_fifo
    import ysyx_24100029_br_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  br_entry_t wdata,
    output br_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    br_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ysyx_24100029_br_commit.sv
// Branch commit: queues predictor updates, raises a one-cycle
// fetch redirect on mispredict and drops wrong-path offers.
module ysyx_24100029_br_commit
    import ysyx_24100029_br_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pred_npc,
    input  logic        ex_is_br,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [1:0]  ex_br_type,
    output logic        br_valid,
    output logic        br_is_taken,
    output logic [31:0] br_pc,
    output logic [1:0]  br_pc_type,
    output logic [31:0] br_npc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int DW = $clog2(FLUSH_CYCLES + 1);

    br_state_t   state;
    br_state_t   state_n;
    logic [DW-1:0] drop_cnt;
    logic [DW-1:0] drop_n;
    br_entry_t   enq_entry;
    br_entry_t   head;
    logic        full;
    logic        empty;
    logic        fire;
    logic        run_fire;
    logic        enq;
    logic        mispredict;
    logic        do_redirect;
    logic [31:0] actual_npc;
    logic        pred_taken_unused;

    // The npc comparison already covers direction, so this is informational.
    assign pred_taken_unused = ex_pred_taken;

    assign actual_npc  = ex_taken ? ex_target : ex_pc + 32'd4;
    assign mispredict  = ex_is_br & (actual_npc != ex_pred_npc);
    assign ex_ready    = ~full | (state == FLUSH);
    assign fire        = ex_valid & ex_ready;
    assign run_fire    = fire & (state == RUN);
    assign enq         = run_fire & ex_is_br;
    assign do_redirect = run_fire & mispredict;

    assign enq_entry = '{
        pc:      ex_pc,
        br_type: ex_br_type,
        npc:     actual_npc,
        taken:   ex_taken
    };

    ysyx_24100029_br_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (enq),
        .pop   (~empty),
        .wdata (enq_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign br_valid    = ~empty;
    assign br_pc       = empty ? 32'd0 : head.pc;
    assign br_pc_type  = empty ? 2'd0  : head.br_type;
    assign br_npc      = empty ? 32'd0 : head.npc;
    assign br_is_taken = ~empty & head.taken;

    always_comb begin
        state_n = state;
        drop_n  = drop_cnt;
        unique case (state)
            RUN: begin
                if (do_redirect) begin
                    state_n = FLUSH;
                    drop_n  = DW'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                drop_n = drop_cnt - DW'(1);
                if (drop_cnt == DW'(1)) begin
                    state_n = RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            drop_cnt       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            br_cnt         <= 32'd0;
            mispred_cnt    <= 32'd0;
        end else begin
            state          <= state_n;
            drop_cnt       <= drop_n;
            redirect_valid <= do_redirect;
            if (do_redirect) begin
                redirect_pc <= actual_npc;
                mispred_cnt <= mispred_cnt + 32'd1;
            end
            if (enq) begin
                br_cnt <= br_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_br_commit.sv
// Directed bench for the branch-commit block with a queue-based
// reference model compared every cycle.
module tb_ysyx_24100029_br_commit;

    localparam int DEPTH = 4;
    localparam int FLUSH = 2;

    logic        clock;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_npc;
    logic        ex_is_br;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [1:0]  ex_br_type;
    logic        br_valid;
    logic        br_is_taken;
    logic [31:0] br_pc;
    logic [1:0]  br_pc_type;
    logic [31:0] br_npc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    ysyx_24100029_br_commit #(
        .FIFO_DEPTH   (DEPTH),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_npc    (ex_pred_npc),
        .ex_is_br       (ex_is_br),
        .ex_taken       (ex_taken),
        .ex_pred_taken  (ex_pred_taken),
        .ex_br_type     (ex_br_type),
        .br_valid       (br_valid),
        .br_is_taken    (br_is_taken),
        .br_pc          (br_pc),
        .br_pc_type     (br_pc_type),
        .br_npc         (br_npc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending updates, a count of
    // offers still to be dropped, and the counters.
    typedef struct {
        logic [31:0] pc;
        logic [1:0]  ty;
        logic [31:0] npc;
        logic        tk;
    } m_ent_t;

    m_ent_t      q[$];
    m_ent_t      m_new;
    int          m_drop;
    bit          m_redir;
    logic [31:0] m_rpc;
    logic [31:0] m_brc;
    logic [31:0] m_mis;
    bit          m_acc;
    bit          m_run;
    logic [31:0] m_npc;

    function automatic bit m_ready();
        return (q.size() < DEPTH) || (m_drop > 0);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_drop  = 0;
            m_redir = 0;
            m_rpc   = 0;
            m_brc   = 0;
            m_mis   = 0;
        end else begin
            m_acc = ex_valid && m_ready();
            m_run = (m_drop == 0);
            m_npc = ex_taken ? ex_target : ex_pc + 32'd4;
            if (q.size() > 0) void'(q.pop_front());
            m_redir = 0;
            if (m_acc && m_run && ex_is_br) begin
                m_new.pc  = ex_pc;
                m_new.ty  = ex_br_type;
                m_new.npc = m_npc;
                m_new.tk  = ex_taken;
                q.push_back(m_new);
                m_brc = m_brc + 1;
                if (m_npc != ex_pred_npc) begin
                    m_mis   = m_mis + 1;
                    m_redir = 1;
                    m_rpc   = m_npc;
                    m_drop  = FLUSH;
                end
            end else if (m_drop > 0) begin
                m_drop = m_drop - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("m_ex_ready", ex_ready, m_ready());
            chk("m_br_valid", br_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("m_br_pc", br_pc, q[0].pc);
                chk("m_br_type", br_pc_type, q[0].ty);
                chk("m_br_npc", br_npc, q[0].npc);
                chk("m_br_taken", br_is_taken, q[0].tk);
            end
            chk("m_redirect", redirect_valid, m_redir);
            if (m_redir) chk("m_redirect_pc", redirect_pc, m_rpc);
            chk("m_br_cnt", br_cnt, m_brc);
            chk("m_mis_cnt", mispred_cnt, m_mis);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_is_br      = 1'b0;
        ex_taken      = 1'b0;
        ex_pred_taken = 1'b0;
        ex_pc         = 32'd0;
        ex_target     = 32'd0;
        ex_pred_npc   = 32'd0;
        ex_br_type    = 2'd0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] pnpc, input logic isbr,
                         input logic tk, input logic [1:0] ty);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_npc   = pnpc;
        ex_is_br      = isbr;
        ex_taken      = tk;
        ex_pred_taken = tk;
        ex_br_type    = ty;
    endtask

    localparam logic [31:0] BASE5 = 32'h8000_1000;

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_br_valid", br_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_br_pc", br_pc, 0);
        chk("rst_br_npc", br_npc, 0);
        chk("rst_br_cnt", br_cnt, 0);
        chk("rst_mis_cnt", mispred_cnt, 0);
        step();
        reset = 1'b1;

        // not-taken branch, correctly predicted
        step();
        offer(32'h8000_0010, 32'h8000_0100, 32'h8000_0014, 1, 0, 2'b00);
        step();
        idle();
        @(negedge clock);
        chk("nt_br_valid", br_valid, 1);
        chk("nt_br_pc", br_pc, 32'h8000_0010);
        chk("nt_br_npc", br_npc, 32'h8000_0014);
        chk("nt_br_taken", br_is_taken, 0);
        chk("nt_redirect", redirect_valid, 0);
        chk("nt_br_cnt", br_cnt, 1);

        // non-branch with bogus prediction: consumed silently
        step();
        offer(32'h8000_0020, 32'd0, 32'h1234_5678, 0, 0, 2'b00);
        step();
        idle();
        @(negedge clock);
        chk("nb_br_valid", br_valid, 0);
        chk("nb_redirect", redirect_valid, 0);
        chk("nb_br_cnt", br_cnt, 1);

        // mispredicted call, then two dropped offers, third enqueued
        step();
        offer(32'h8000_0100, 32'h8000_0400, 32'h8000_0104, 1, 1, 2'b01);
        step();
        offer(32'h8000_0300, 32'h8000_0500, 32'h8000_0304, 1, 1, 2'b00);
        @(negedge clock);
        chk("mp_redirect", redirect_valid, 1);
        chk("mp_redirect_pc", redirect_pc, 32'h8000_0400);
        chk("mp_br_valid", br_valid, 1);
        chk("mp_br_type", br_pc_type, 2'b01);
        chk("mp_br_npc", br_npc, 32'h8000_0400);
        chk("mp_mis_cnt", mispred_cnt, 1);
        chk("mp_br_cnt", br_cnt, 2);
        step();
        offer(32'h8000_0310, 32'h8000_0600, 32'h8000_0314, 1, 1, 2'b10);
        @(negedge clock);
        chk("fl_redirect_off", redirect_valid, 0);
        chk("fl_ex_ready", ex_ready, 1);
        chk("fl_br_valid", br_valid, 0);
        step();
        offer(32'h8000_0200, 32'd0, 32'h8000_0204, 1, 0, 2'b00);
        @(negedge clock);
        chk("fl_br_valid2", br_valid, 0);
        chk("fl_br_cnt", br_cnt, 2);
        chk("fl_mis_cnt", mispred_cnt, 1);
        step();
        idle();
        @(negedge clock);
        chk("af_br_valid", br_valid, 1);
        chk("af_br_pc", br_pc, 32'h8000_0200);
        chk("af_br_cnt", br_cnt, 3);
        chk("af_redirect", redirect_valid, 0);

        // pc+4 wraps to zero
        step();
        offer(32'hFFFF_FFFC, 32'd0, 32'd0, 1, 0, 2'b00);
        step();
        idle();
        @(negedge clock);
        chk("wr_br_npc", br_npc, 32'd0);
        chk("wr_redirect", redirect_valid, 0);
        chk("wr_br_cnt", br_cnt, 4);

        // five back-to-back branches emerge in order
        for (int i = 0; i < 5; i++) begin
            step();
            offer(BASE5 + 32'(4 * i), 32'd0, BASE5 + 32'(4 * i + 4),
                  1, 0, 2'(i % 3));
            @(negedge clock);
            chk("b2b_ex_ready", ex_ready, 1);
            if (i > 0) chk("b2b_br_pc", br_pc, BASE5 + 32'(4 * (i - 1)));
        end
        step();
        idle();
        @(negedge clock);
        chk("b2b_last_pc", br_pc, BASE5 + 32'd16);
        step();
        @(negedge clock);
        chk("b2b_drained", br_valid, 0);
        chk("b2b_br_cnt", br_cnt, 9);

        // sustained taken traffic: queue never overflows
        for (int i = 0; i < 5; i++) begin
            step();
            offer(32'h8000_2000 + 32'(16 * i), 32'h8000_3000 + 32'(256 * i),
                  32'h8000_3000 + 32'(256 * i), 1, 1, 2'b10);
            @(negedge clock);
            chk("full_ex_ready", ex_ready, 1);
        end
        step();
        idle();
        @(negedge clock);
        chk("full_last_npc", br_npc, 32'h8000_3400);
        chk("full_br_cnt", br_cnt, 14);
        chk("full_mis_cnt", mispred_cnt, 1);
        step();

        // reset right after a mispredict transfer
        offer(32'h8000_4000, 32'h8000_4800, 32'h8000_4004, 1, 1, 2'b00);
        step();
        reset = 1'b0;
        idle();
        @(negedge clock);
        chk("rr_redirect", redirect_valid, 0);
        chk("rr_br_valid", br_valid, 0);
        chk("rr_br_cnt", br_cnt, 0);
        chk("rr_mis_cnt", mispred_cnt, 0);
        chk("rr_ex_ready", ex_ready, 1);
        step();
        reset = 1'b1;
        step();
        offer(32'h8000_5000, 32'd0, 32'h8000_5004, 1, 0, 2'b00);
        @(negedge clock);
        chk("rr_no_pulse", redirect_valid, 0);
        step();
        idle();
        @(negedge clock);
        chk("rr_run_br_valid", br_valid, 1);
        chk("rr_run_br_pc", br_pc, 32'h8000_5000);
        chk("rr_run_br_cnt", br_cnt, 1);
        chk("rr_run_redirect", redirect_valid, 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
